// File: rtl/render_frame_sequencer.sv
// Frame sequencer for the main_process_0 transform core: double-buffers the transform
// parameters, issues ap_start, snoops the output stream for frame end and reports status.
module render_frame_sequencer #(
   parameter int unsigned MATRIX_WIDTH   = 16,
   parameter int unsigned COORD_WIDTH    = 19,
   parameter int unsigned SCALE_WIDTH    = 12,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic [9*MATRIX_WIDTH-1:0] cfg_matrix,
   input  logic [3*COORD_WIDTH-1:0]  cfg_p,
   input  logic [SCALE_WIDTH-1:0]    cfg_yscale,
   input  logic [SCALE_WIDTH-1:0]    cfg_zscale,
   input  logic                      cfg_commit,
   input  logic                      cfg_run,
   input  logic                      cfg_abort,
   input  logic [31:0]               cfg_frame_pixels,
   output logic [9*MATRIX_WIDTH-1:0] act_matrix,
   output logic [3*COORD_WIDTH-1:0]  act_p,
   output logic [SCALE_WIDTH-1:0]    act_yscale,
   output logic [SCALE_WIDTH-1:0]    act_zscale,
   output logic                      ap_start,
   input  logic                      os_tvalid,
   input  logic                      os_tready,
   input  logic                      os_tlast,
   output logic                      busy,
   output logic                      frame_done,
   output logic [31:0]               frame_count,
   output logic                      pending,
   output logic                      err_short,
   output logic                      err_long,
   output logic                      err_timeout
);

   localparam int unsigned MAT_W   = 9 * MATRIX_WIDTH;
   localparam int unsigned P_W     = 3 * COORD_WIDTH;
   localparam int unsigned CNT_W   = 32;
   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [MAT_W-1:0]       r_sh_matrix, r_act_matrix;
   logic [P_W-1:0]         r_sh_p, r_act_p;
   logic [SCALE_WIDTH-1:0] r_sh_yscale, r_act_yscale;
   logic [SCALE_WIDTH-1:0] r_sh_zscale, r_act_zscale;
   logic [CNT_W-1:0]       r_beat_cnt, r_wd_cnt, r_frame_count;
   logic                   r_pending, r_ap_start, r_busy, r_frame_done;
   logic                   r_err_short, r_err_long, r_err_timeout;

   logic                   w_beat;
   logic [CNT_W-1:0]       w_beat_inc;
   logic                   w_load;
   logic                   w_set_short, w_set_long, w_set_timeout;

   assign w_beat     = os_tvalid & os_tready;
   assign w_beat_inc = r_beat_cnt + CNT_W'(1);
   assign w_load     = (r_state == S_LOAD) && !cfg_abort;

   // Next state and error events; abort overrides every transition
   always_comb begin
      w_next        = r_state;
      w_set_short   = 1'b0;
      w_set_long    = 1'b0;
      w_set_timeout = 1'b0;
      case (r_state)
         S_IDLE:  if (cfg_run) w_next = S_LOAD;
         S_LOAD:  w_next = S_START;
         S_START: w_next = S_RUN;
         S_RUN: begin
            if (w_beat) begin
               if (os_tlast) begin
                  w_next      = S_DONE;
                  w_set_short = (cfg_frame_pixels != '0) && (w_beat_inc < cfg_frame_pixels);
               end else if ((cfg_frame_pixels != '0) && (w_beat_inc == cfg_frame_pixels)) begin
                  w_next     = S_DONE;
                  w_set_long = 1'b1;
               end
            end else if (WD_EN && (r_wd_cnt == WD_LAST)) begin
               w_next        = S_IDLE;
               w_set_timeout = 1'b1;
            end
         end
         S_DONE:  w_next = cfg_run ? S_LOAD : S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (cfg_abort) begin
         w_next        = S_IDLE;
         w_set_short   = 1'b0;
         w_set_long    = 1'b0;
         w_set_timeout = 1'b0;
      end
   end

   // State register and registered control outputs
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_ap_start    <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state      <= w_next;
         r_busy       <= (w_next != S_IDLE);
         r_ap_start   <= (w_next == S_START);
         r_frame_done <= (w_next == S_DONE);
         if ((r_state == S_RUN) && (w_next == S_DONE))
            r_frame_count <= r_frame_count + CNT_W'(1);
      end
   end

   // Beat and watchdog counters, live only in RUN
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_beat_cnt <= '0;
         r_wd_cnt   <= '0;
      end else if (cfg_abort || (r_state == S_LOAD)) begin
         r_beat_cnt <= '0;
         r_wd_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         if (w_beat) begin
            r_beat_cnt <= w_beat_inc;
            r_wd_cnt   <= '0;
         end else begin
            r_wd_cnt   <= r_wd_cnt + CNT_W'(1);
         end
      end
   end

   // Shadow/active banks; a commit coinciding with LOAD lands in the shadow only
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_sh_matrix  <= '0;
         r_sh_p       <= '0;
         r_sh_yscale  <= '0;
         r_sh_zscale  <= '0;
         r_act_matrix <= '0;
         r_act_p      <= '0;
         r_act_yscale <= '0;
         r_act_zscale <= '0;
         r_pending    <= 1'b0;
      end else begin
         if (cfg_commit) begin
            r_sh_matrix <= cfg_matrix;
            r_sh_p      <= cfg_p;
            r_sh_yscale <= cfg_yscale;
            r_sh_zscale <= cfg_zscale;
         end
         if (w_load) begin
            r_act_matrix <= r_sh_matrix;
            r_act_p      <= r_sh_p;
            r_act_yscale <= r_sh_yscale;
            r_act_zscale <= r_sh_zscale;
         end
         if (cfg_commit)  r_pending <= 1'b1;
         else if (w_load) r_pending <= 1'b0;
      end
   end

   // Sticky error flags, cleared by a commit while idle
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_err_short   <= 1'b0;
         r_err_long    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else if (cfg_commit && (r_state == S_IDLE)) begin
         r_err_short   <= 1'b0;
         r_err_long    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         if (w_set_short)   r_err_short   <= 1'b1;
         if (w_set_long)    r_err_long    <= 1'b1;
         if (w_set_timeout) r_err_timeout <= 1'b1;
      end
   end

   assign act_matrix  = r_act_matrix;
   assign act_p       = r_act_p;
   assign act_yscale  = r_act_yscale;
   assign act_zscale  = r_act_zscale;
   assign ap_start    = r_ap_start;
   assign busy        = r_busy;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign pending     = r_pending;
   assign err_short   = r_err_short;
   assign err_long    = r_err_long;
   assign err_timeout = r_err_timeout;

endmodule
